// File: rtl/second_m_if.sv
// Operand/result bundle for the registered 4-bit carry-lookahead adder.
// The Z/V flag signals exist only when SECOND_M_FLAGS_EN is defined.
interface second_m_if;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] F;
    logic       C4;
    logic       out_valid;
`ifdef SECOND_M_FLAGS_EN
    logic       Z;
    logic       V;
`endif

    modport master (
        output in_valid, A, B, C0,
        input  F, C4, out_valid
`ifdef SECOND_M_FLAGS_EN
        , input Z, V
`endif
    );

    modport slave (
        input  in_valid, A, B, C0,
        output F, C4, out_valid
`ifdef SECOND_M_FLAGS_EN
        , output Z, V
`endif
    );
endinterface

// File: rtl/second_m.sv
// 4-bit carry-lookahead adder with a single registered output stage.
// Define SECOND_M_FLAGS_EN to add registered zero (Z) and signed-overflow (V) flags.
module second_m (
    input logic     clk,
    input logic     rst,
    second_m_if.slave bus
);
    logic [3:0] g, p;
    logic [4:0] c;
    logic [3:0] f_d, f_q;
    logic       c4_q, vld_q;

    assign g    = bus.A & bus.B;
    assign p    = bus.A ^ bus.B;
    assign c[0] = bus.C0;

    // Every carry is a flat sum of products of G/P/C0; no carry feeds another.
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign f_d = p ^ c[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q   <= 4'd0;
            c4_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                f_q  <= f_d;
                c4_q <= c[4];
            end
        end
    end

    assign bus.F         = f_q;
    assign bus.C4        = c4_q;
    assign bus.out_valid = vld_q;

`ifdef SECOND_M_FLAGS_EN
    logic z_q, v_q;

    // Z resets to 1 so it stays consistent with the cleared F.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b1;
            v_q <= 1'b0;
        end else if (bus.in_valid) begin
            z_q <= (f_d == 4'd0);
            v_q <= c[3] ^ c[4];
        end
    end

    assign bus.Z = z_q;
    assign bus.V = v_q;
`endif
endmodule

// File: tb/tb_second_m.sv
// Randomized and directed checks of second_m against an arithmetic reference model.
module tb_second_m;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] exp_f;
    logic       exp_c4, exp_vld, exp_z, exp_v;

    second_m_if bus ();
    second_m dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_f = 4'd0; exp_c4 = 1'b0; exp_vld = 1'b0; exp_z = 1'b1; exp_v = 1'b0;
    endtask

    // Reference: plain integer arithmetic, signed overflow from the signed-range test.
    task automatic model_load(input logic [3:0] a, input logic [3:0] b, input logic c);
        int s, sa, sb, ss;
        s      = int'(a) + int'(b) + int'(c);
        exp_f  = 4'(s % 16);
        exp_c4 = (s > 15);
        exp_z  = (s % 16 == 0);
        sa     = (a >= 8) ? int'(a) - 16 : int'(a);
        sb     = (b >= 8) ? int'(b) - 16 : int'(b);
        ss     = sa + sb + int'(c);
        exp_v  = (ss > 7) || (ss < -8);
    endtask

    task automatic check_outputs(input string tag);
        check(tag, {5'd0, bus.out_valid, bus.C4, 1'b0} | {4'd0, bus.F},
              {5'd0, exp_vld, exp_c4, 1'b0} | {4'd0, exp_f});
`ifdef SECOND_M_FLAGS_EN
        check({tag, "_zv"}, {6'd0, bus.Z, bus.V}, {6'd0, exp_z, exp_v});
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic c);
        @(negedge clk);
        bus.in_valid = v; bus.A = a; bus.B = b; bus.C0 = c;
        @(posedge clk);
        if (v) model_load(a, b, c);
        exp_vld = v;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.A = 4'd0; bus.B = 4'd0; bus.C0 = 1'b0;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_outputs("rst_async");
        bus.in_valid = 1'b1; bus.A = 4'd9; bus.B = 4'd9;
        @(negedge clk);
        check_outputs("rst_ignores_valid");
        bus.in_valid = 1'b0;
        rst = 1'b0;

        step("r24", 1'b1, 4'b0001, 4'b0001, 1'b0);
        check("r24_const", {4'd0, bus.F}, 8'h02);
        step("r25a", 1'b1, 4'b0000, 4'b1111, 1'b0);
        step("r25b", 1'b1, 4'b0000, 4'b1111, 1'b1);
        check("r25b_const", {3'd0, bus.C4, bus.F}, 8'h10);
        step("r26a", 1'b1, 4'b1111, 4'b1111, 1'b0);
        step("r26b", 1'b1, 4'b0111, 4'b0001, 1'b0);
        step("max", 1'b1, 4'b1111, 4'b1111, 1'b1);
        check("max_const", {3'd0, bus.C4, bus.F}, 8'h1F);

        // Back-to-back results, then idle cycles hold the last result.
        step("b2b0", 1'b1, 4'd3, 4'd4, 1'b0);
        step("b2b1", 1'b1, 4'd9, 4'd8, 1'b1);
        step("b2b2", 1'b1, 4'd12, 4'd2, 1'b0);
        step("idle0", 1'b0, 4'd5, 4'd5, 1'b1);
        step("idle1", 1'b0, 4'd1, 4'd0, 1'b0);
        check("idle_hold", {3'd0, bus.C4, bus.F}, 8'h0E);

        // Exhaustive sweep, one operand set per cycle.
        for (int i = 0; i < 512; i++)
            step("sweep", 1'b1, 4'(i >> 5), 4'(i >> 1), i[0]);

        // Mid-stream reset discards the pending operation.
        step("pre_rst", 1'b1, 4'd6, 4'd7, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.A = 4'd5; bus.B = 4'd5; bus.C0 = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("rst_mid");
        @(posedge clk);
        #1 check_outputs("rst_hold");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step("post_rst", 1'b1, 4'd2, 4'd2, 1'b0);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/second_m.md
SECOND_M -- requirements
Module: second_m

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  qualifies A, B, C0 this cycle.
REQ-005 A  input  4  operand A, unsigned / two's complement.
REQ-006 B  input  4  operand B.
REQ-007 C0  input  1  carry-in.
REQ-008 F  output  4  registered sum bits, (A+B+C0) mod 16.
REQ-009 C4  output  1  registered carry-out, bit 4 of A+B+C0.
REQ-010 out_valid  output  1  F/C4 (and flags) hold a result computed from a valid input.
REQ-011 Z, V  output  1 each  zero flag and signed-overflow flag; present only with SECOND_M_FLAGS_EN.

Function
REQ-012 The sum SHALL be computed by a 4-bit carry-lookahead network:
- Gi=Ai&Bi, Pi=Ai^Bi.
- C1..C4 from flattened G/P/C0 equations, no ripple chain.
- Fi=Pi^Ci.
REQ-013 When in_valid=1 at a rising edge: F and C4 load the new result; out_valid loads 1.
- Latency: exactly 1 clock.
REQ-014 When in_valid=0 at a rising edge: F and C4 hold their previous values; out_valid loads 0.
REQ-015 Full 9-bit input range is legal; wrap-around SHALL set C4=1 whenever A+B+C0>15 (e.g. 15+15+1 -> F=15, C4=1).
REQ-016 Back-to-back valid inputs SHALL produce one result per cycle with no bubbles.
REQ-017 No combinational path SHALL exist from any input to any output.

Reset
REQ-018 rst=1 SHALL immediately, without a clock edge, force:
- F=0, C4=0, out_valid=0.
- Z=1 and V=0 when the flags are compiled in.
REQ-019 While rst=1, in_valid SHALL be ignored.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; the first valid input sampled after rst deasserts SHALL appear one cycle later.

Configuration
REQ-021 Macro SECOND_M_FLAGS_EN defined:
- Z and V ports exist and register together with F.
- Z=1 iff F==0.
- V=1 iff C3^C4 (signed overflow).
REQ-022 Macro SECOND_M_FLAGS_EN undefined: Z and V and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 rst pulse mid-cycle with prior nonzero outputs -> F=0, C4=0, out_valid=0 immediately, before the next clk edge.
REQ-024 A=0001, B=0001, C0=0, in_valid=1 -> next cycle F=0010, C4=0, out_valid=1.
REQ-025 A=0000, B=1111, C0=0 -> F=1111, C4=0; then the same operands with C0=1 -> F=0000, C4=1, Z=1 (flags build).
REQ-026 A=1111, B=1111, C0=0 -> F=1110, C4=1, V=0; A=0111, B=0001, C0=0 -> F=1000, C4=0, V=1.
REQ-027 Valid inputs on consecutive cycles, then in_valid=0 -> each result appears 1 cycle later; out_valid drops while F/C4 hold the last result.
REQ-028 Exhaustive sweep of all 512 (A,B,C0) combinations -> {C4,F} equals A+B+C0 every cycle.
